// File: rtl/dpram_pkg.sv
// dpram_pkg
// Shared constants and types for the dual-port RAM slice.
//   DPRAM_WIDTH / DPRAM_DEPTH / DPRAM_ADDR_SIZE : default geometry (16 x 8)
//   dpram_word_t / dpram_addr_t                 : word and address types at
//                                                 the default geometry
package dpram_pkg;

  localparam int DPRAM_WIDTH     = 8;
  localparam int DPRAM_DEPTH     = 16;
  localparam int DPRAM_ADDR_SIZE = 4;

  typedef logic [DPRAM_WIDTH-1:0]     dpram_word_t;
  typedef logic [DPRAM_ADDR_SIZE-1:0] dpram_addr_t;

endpackage : dpram_pkg

// File: rtl/dpram_array.sv
// dpram_array
// Reset-able storage array with a synchronous write port and a
// combinational read tap. The top level registers the tap.
// Ports:
//   clk     : clock, writes on rising edge
//   reset   : asynchronous active-low reset, clears every word
//   we      : write enable
//   we_addr : write address
//   din     : write data
//   rd_addr : read tap address
//   rd_data : combinational read tap, mem[rd_addr] (pre-write contents)
module dpram_array
  import dpram_pkg::*;
#(
  parameter int WIDTH     = DPRAM_WIDTH,
  parameter int DEPTH     = DPRAM_DEPTH,
  parameter int ADDR_SIZE = DPRAM_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] we_addr,
  input  logic [WIDTH-1:0]     din,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The whole array is cleared on reset so reads never return X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[we_addr] <= din;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : dpram_array

// File: rtl/dual_port_ram_sync.sv
// dual_port_ram_sync
// Simple dual-port RAM, one write port and one read port on one clock,
// registered read data (1-cycle latency).
// There is no handshake: a write and/or a read may be issued every cycle,
// each qualified only by its own enable (we / re), independently.
// Build option:
//   DPRAM_WR_BYPASS_EN defined   : same-address read-during-write returns din
//                                  (write-first)
//   DPRAM_WR_BYPASS_EN undefined : returns the old contents (read-first)
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset (dout and memory cleared)
//   we      : write enable
//   re      : read enable; dout holds when low
//   we_addr : write address
//   rd_addr : read address
//   din     : write data
//   dout    : registered read data
module dual_port_ram_sync
  import dpram_pkg::*;
#(
  parameter int WIDTH     = DPRAM_WIDTH,
  parameter int DEPTH     = DPRAM_DEPTH,
  parameter int ADDR_SIZE = DPRAM_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] we_addr,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout
);

  generate
    if (DEPTH != (2 ** ADDR_SIZE)) begin : g_bad_geometry
      $error("dual_port_ram_sync: DEPTH must equal 2**ADDR_SIZE");
    end
  endgenerate

  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] rd_next;

  dpram_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .we_addr (we_addr),
    .din     (din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The tap shows the array before this edge's write lands, which gives
  // read-first naturally; the bypass forwards din instead on a collision.
`ifdef DPRAM_WR_BYPASS_EN
  always_comb begin
    rd_next = rd_data;
    if (we && (we_addr == rd_addr)) begin
      rd_next = din;
    end
  end
`else
  always_comb begin
    rd_next = rd_data;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (re) begin
      dout <= rd_next;
    end
  end

endmodule : dual_port_ram_sync

// File: tb/tb_dual_port_ram_sync.sv
module tb_dual_port_ram_sync;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_SIZE = 4;

  // clock / reset
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 we;
  logic                 re;
  logic [ADDR_SIZE-1:0] we_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [WIDTH-1:0]     din;
  logic [WIDTH-1:0]     dout;

  always #5 clk = ~clk;

  dual_port_ram_sync #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .re      (re),
    .we_addr (we_addr),
    .rd_addr (rd_addr),
    .din     (din),
    .dout    (dout)
  );

  int vectors_applied = 0;
  int miscompares     = 0;

  // checking
  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // driver tasks: advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_SIZE-1:0] a, input logic [WIDTH-1:0] d);
    we = 1'b1; we_addr = a; din = d; re = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [ADDR_SIZE-1:0] a);
    re = 1'b1; rd_addr = a; we = 1'b0;
    tick();
    idle();
  endtask

  logic [WIDTH-1:0] exp_collide;

  initial begin
    reset = 1'b0; we = 1'b0; re = 1'b0;
    we_addr = '0; rd_addr = '0; din = '0;
    tick(); tick();
    check("reset_dout", dout, 8'h00);

    // 1. reset: async clear of dout, memory cleared
    reset = 1'b1;
    tick();
    do_write(4'd5, 8'h77);
    do_read(4'd5);
    check("pre_reset_read5", dout, 8'h77);
    #3 reset = 1'b0;
    #1 check("async_reset_dout", dout, 8'h00);
    re = 1'b1; rd_addr = 4'd5;          // ignored while reset is low
    tick();
    check("reset_held_dout", dout, 8'h00);
    #2 reset = 1'b1;
    tick();
    idle();
    check("post_reset_read5", dout, 8'h00);

    // 2. fill and read back
    for (int k = 0; k < DEPTH; k++) begin
      we = 1'b1; we_addr = ADDR_SIZE'(k); din = WIDTH'(k);
      tick();
    end
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      re = 1'b1; rd_addr = ADDR_SIZE'(k);
      tick();
      check($sformatf("fill_read%0d", k), dout, WIDTH'(k));
    end
    idle();

    // 3. hold with re=0
    do_read(4'd3);
    check("hold_read3", dout, 8'h03);
    re = 1'b0; rd_addr = 4'd9;
    tick();
    check("hold_cycle1", dout, 8'h03);
    tick();
    check("hold_cycle2", dout, 8'h03);

    // 4. concurrent write/read, different addresses
    we = 1'b1; we_addr = 4'd7; din = 8'hA5;
    re = 1'b1; rd_addr = 4'd2;
    tick();
    idle();
    check("concurrent_read2", dout, 8'h02);
    do_read(4'd7);
    check("concurrent_read7", dout, 8'hA5);

    // 5. same-address collision
`ifdef DPRAM_WR_BYPASS_EN
    exp_collide = 8'h5A;
`else
    exp_collide = 8'h04;
`endif
    we = 1'b1; we_addr = 4'd4; din = 8'h5A;
    re = 1'b1; rd_addr = 4'd4;
    tick();
    idle();
    check("collide_dout", dout, exp_collide);
    do_read(4'd4);
    check("collide_mem4", dout, 8'h5A);

    // 6. reset mid-stream discards the in-flight write
    do_write(4'd1, 8'hFF);
    do_read(4'd1);
    check("mid_pre_read1", dout, 8'hFF);
    we = 1'b1; we_addr = 4'd2; din = 8'h22;
    #3 reset = 1'b0;
    #1 check("mid_async_dout", dout, 8'h00);
    tick();
    idle();
    #2 reset = 1'b1;
    do_read(4'd1);
    check("mid_read1", dout, 8'h00);
    do_read(4'd2);
    check("mid_read2", dout, 8'h00);
    do_read(4'd4);
    check("mid_read4", dout, 8'h00);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule : tb_dual_port_ram_sync
